// File: rtl/scan_decoder.sv
// Binary-to-one-hot decoder with a registered output. DIRECT mode decodes handshaked
// select codes; SCAN mode walks the one-hot position with a programmable dwell and blanking.
module scan_decoder #(
  parameter int N_OUT = 8,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       mode,
  input  logic [$clog2(N_OUT)-1:0]   din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [N_OUT-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(N_OUT)-1:0]   idx,
  output logic                       wrap,
  output logic                       err
);

  localparam int SEL_W   = $clog2(N_OUT);
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SHOW   = 2'd2,
    BLNK   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [N_OUT-1:0]     dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     idx_next;
  logic                 accept;
  logic                 din_in_range;

  function automatic logic [N_OUT-1:0] one_hot(input logic [SEL_W-1:0] sel);
    logic [N_OUT-1:0] base;
    base = {{(N_OUT-1){1'b0}}, 1'b1};
    return base << sel;
  endfunction

  assign din_ready    = (state_q == DIRECT);
  assign accept       = din_valid & din_ready;
  assign din_in_range = ({1'b0, din} < (SEL_W+1)'(N_OUT));
  assign idx_next     = (idx_q == SEL_W'(N_OUT - 1)) ? {SEL_W{1'b0}} : idx_q + SEL_W'(1);

  // cnt counts cycles already spent in the current SHOW or BLNK phase, including this one.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    idx_d        = idx_q;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    if (!en) begin
      state_d = IDLE;
      dout_d  = {N_OUT{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (mode) begin
            state_d      = SHOW;
            dout_d       = one_hot(idx_q);
            dout_valid_d = 1'b1;
            cnt_d        = CNT_W'(1);
          end else begin
            state_d = DIRECT;
            dout_d  = {N_OUT{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
          end
        end
        DIRECT: begin
          if (mode) begin
            state_d = IDLE;
            dout_d  = {N_OUT{1'b0}};
          end else if (accept) begin
            if (din_in_range) begin
              dout_d       = one_hot(din);
              idx_d        = din;
              dout_valid_d = 1'b1;
            end else begin
              dout_d = {N_OUT{1'b0}};
              err_d  = 1'b1;
            end
          end else begin
            dout_d = dout_q;
          end
        end
        SHOW: begin
          if (!mode) begin
            state_d = IDLE;
            dout_d  = {N_OUT{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
          end else if (cnt_q < CNT_W'(DWELL)) begin
            dout_valid_d = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
          end else if (BLANK > 0) begin
            state_d = BLNK;
            dout_d  = {N_OUT{1'b0}};
            cnt_d   = CNT_W'(1);
          end else begin
            idx_d        = idx_next;
            dout_d       = one_hot(idx_next);
            dout_valid_d = 1'b1;
            wrap_d       = (idx_q == SEL_W'(N_OUT - 1));
            cnt_d        = CNT_W'(1);
          end
        end
        BLNK: begin
          if (!mode) begin
            state_d = IDLE;
            dout_d  = {N_OUT{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
          end else if (cnt_q < CNT_W'(BLANK)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d      = SHOW;
            idx_d        = idx_next;
            dout_d       = one_hot(idx_next);
            dout_valid_d = 1'b1;
            wrap_d       = (idx_q == SEL_W'(N_OUT - 1));
            cnt_d        = CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          dout_d  = {N_OUT{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dout_q       <= {N_OUT{1'b0}};
      dout_valid_q <= 1'b0;
      idx_q        <= {SEL_W{1'b0}};
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign idx        = idx_q;
  assign wrap       = wrap_q;
  assign err        = err_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: four instances with different parameters share
// one set of inputs; each task checks the instance relevant to its scenario.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode, din_valid;
  logic [2:0] din;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic       rdy8, dv8, wr8, er8;
  logic [7:0] do8;
  logic [2:0] ix8;
  scan_decoder #(.N_OUT(8), .DWELL(4), .BLANK(1)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .din_ready(rdy8), .dout(do8), .dout_valid(dv8), .idx(ix8), .wrap(wr8), .err(er8));

  logic       rdy6, dv6, wr6, er6;
  logic [5:0] do6;
  logic [2:0] ix6;
  scan_decoder #(.N_OUT(6), .DWELL(4), .BLANK(1)) u6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .din_ready(rdy6), .dout(do6), .dout_valid(dv6), .idx(ix6), .wrap(wr6), .err(er6));

  logic       rdy3, dv3, wr3, er3;
  logic [2:0] do3;
  logic [1:0] ix3;
  scan_decoder #(.N_OUT(3), .DWELL(2), .BLANK(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din[1:0]), .din_valid(din_valid),
    .din_ready(rdy3), .dout(do3), .dout_valid(dv3), .idx(ix3), .wrap(wr3), .err(er3));

  logic       rdy4, dv4, wr4, er4;
  logic [3:0] do4;
  logic [1:0] ix4;
  scan_decoder #(.N_OUT(4), .DWELL(1), .BLANK(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din[1:0]), .din_valid(din_valid),
    .din_ready(rdy4), .dout(do4), .dout_valid(dv4), .idx(ix4), .wrap(wr4), .err(er4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; din = 3'd0; din_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({do8, dv8, ix8, wr8, er8, rdy8} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: dout=%h dv=%b idx=%0d wrap=%b err=%b rdy=%b, expected all zero",
               do8, dv8, ix8, wr8, er8, rdy8);
    end
    checks++;
    if ({do3, dv3, ix3, wr3, er3} !== {3'b000, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_n3: dout=%b dv=%b idx=%0d wrap=%b err=%b, expected all zero",
               do3, dv3, ix3, wr3, er3);
    end
  endtask

  task automatic test_direct();
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    tick();
    checks++;
    if (rdy8 !== 1'b1 || do8 !== 8'h00) begin
      failures++;
      $display("FAIL direct_entry: rdy=%b dout=%h, expected rdy=1 dout=00", rdy8, do8);
    end
    din = 3'd5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (do8 !== 8'h20 || dv8 !== 1'b1 || ix8 !== 3'd5) begin
      failures++;
      $display("FAIL direct_5: dout=%h dv=%b idx=%0d, expected 20/1/5", do8, dv8, ix8);
    end
    tick();
    checks++;
    if (do8 !== 8'h20 || dv8 !== 1'b0 || ix8 !== 3'd5) begin
      failures++;
      $display("FAIL direct_hold: dout=%h dv=%b idx=%0d, expected 20/0/5", do8, dv8, ix8);
    end
    // back-to-back accepts
    din = 3'd1; din_valid = 1'b1;
    tick();
    checks++;
    if (do8 !== 8'h02 || dv8 !== 1'b1 || ix8 !== 3'd1) begin
      failures++;
      $display("FAIL b2b_first: dout=%h dv=%b idx=%0d, expected 02/1/1", do8, dv8, ix8);
    end
    din = 3'd3;
    tick();
    din_valid = 1'b0;
    checks++;
    if (do8 !== 8'h08 || dv8 !== 1'b1 || ix8 !== 3'd3) begin
      failures++;
      $display("FAIL b2b_second: dout=%h dv=%b idx=%0d, expected 08/1/3", do8, dv8, ix8);
    end
  endtask

  task automatic test_err();
    din = 3'd7; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (do6 !== 6'h00 || er6 !== 1'b1 || ix6 !== 3'd3 || dv6 !== 1'b0) begin
      failures++;
      $display("FAIL err_n6: dout=%h err=%b idx=%0d dv=%b, expected 00/1/3/0", do6, er6, ix6, dv6);
    end
    checks++;
    if (do8 !== 8'h80 || er8 !== 1'b0 || ix8 !== 3'd7) begin
      failures++;
      $display("FAIL din7_n8: dout=%h err=%b idx=%0d, expected 80/0/7", do8, er8, ix8);
    end
    tick();
    checks++;
    if (er6 !== 1'b0 || ix6 !== 3'd3) begin
      failures++;
      $display("FAIL err_pulse: err=%b idx=%0d, expected 0/3", er6, ix6);
    end
  endtask

  task automatic test_scan();
    logic [2:0] exp3 [10] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000,
                              3'b100, 3'b100, 3'b000, 3'b001};
    logic [3:0] exp4 [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (do3 !== exp3[i] || wr3 !== (i == 9) || dv3 !== (exp3[i] != 3'b000)) begin
        failures++;
        $display("FAIL scan_n3[%0d]: dout=%b wrap=%b dv=%b, expected %b wrap=%b",
                 i, do3, wr3, dv3, exp3[i], (i == 9));
      end
      checks++;
      if (do4 !== exp4[i] || dv4 !== 1'b1 || wr4 !== (i == 4 || i == 8)) begin
        failures++;
        $display("FAIL scan_n4[%0d]: dout=%h dv=%b wrap=%b, expected %h dv=1 wrap=%b",
                 i, do4, dv4, wr4, exp4[i], (i == 4 || i == 8));
      end
    end
  endtask

  task automatic test_mode_flip();
    tick(); tick();
    checks++;
    if (do8 !== 8'h04 || ix8 !== 3'd2 || dv8 !== 1'b1 || rdy8 !== 1'b0) begin
      failures++;
      $display("FAIL flip_pre: dout=%h idx=%0d dv=%b rdy=%b, expected 04/2/1/0", do8, ix8, dv8, rdy8);
    end
    mode = 1'b0;
    tick();
    checks++;
    if (do8 !== 8'h00 || dv8 !== 1'b0 || ix8 !== 3'd2 || rdy8 !== 1'b0) begin
      failures++;
      $display("FAIL flip_idle: dout=%h dv=%b idx=%0d rdy=%b, expected 00/0/2/0", do8, dv8, ix8, rdy8);
    end
    tick();
    checks++;
    if (rdy8 !== 1'b1 || ix8 !== 3'd2 || do8 !== 8'h00) begin
      failures++;
      $display("FAIL flip_direct: rdy=%b idx=%0d dout=%h, expected 1/2/00", rdy8, ix8, do8);
    end
    din = 3'd6; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (do8 !== 8'h40 || ix8 !== 3'd6 || dv8 !== 1'b1) begin
      failures++;
      $display("FAIL flip_accept: dout=%h idx=%0d dv=%b, expected 40/6/1", do8, ix8, dv8);
    end
  endtask

  task automatic test_rst_mid_show();
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 22; i++) tick();
    checks++;
    if (do8 !== 8'h10 || ix8 !== 3'd4 || dv8 !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: dout=%h idx=%0d dv=%b, expected 10/4/1", do8, ix8, dv8);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (do8 !== 8'h00 || dv8 !== 1'b0 || ix8 !== 3'd0 || rdy8 !== 1'b0 || wr8 !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: dout=%h dv=%b idx=%0d rdy=%b wrap=%b, expected 00/0/0/0/0",
               do8, dv8, ix8, rdy8, wr8);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (do8 !== 8'h01 || ix8 !== 3'd0 || dv8 !== 1'b1 || wr8 !== 1'b0) begin
      failures++;
      $display("FAIL rst_reentry: dout=%h idx=%0d dv=%b wrap=%b, expected 01/0/1/0", do8, ix8, dv8, wr8);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_err();
    test_scan();
    test_mode_flip();
    test_rst_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
